// File: rtl/lc3_keyboard_fifo_if.sv
// CPU-side register strobes plus the keyboard character strobe for the LC-3 keyboard FIFO.
// master drives the strobes and data; slave returns KBDR, KBSR and KB_INT.
interface lc3_keyboard_fifo_if #(
    parameter int CHAR_W = 8
);
    logic              LD_KBSR;
    logic              RD_KBDR;
    logic [15:0]       DATA;
    logic [CHAR_W-1:0] I_char;
    logic              LD_char;
    logic [15:0]       KBDR;
    logic [15:0]       KBSR;
    logic              KB_INT;

    modport master (
        output LD_KBSR, RD_KBDR, DATA, I_char, LD_char,
        input  KBDR, KBSR, KB_INT
    );

    modport slave (
        input  LD_KBSR, RD_KBDR, DATA, I_char, LD_char,
        output KBDR, KBSR, KB_INT
    );
endinterface

// File: rtl/lc3_keyboard_fifo.sv
// LC-3 keyboard data/status registers backed by a DEPTH-entry character FIFO.
// Outputs are combinational from state; no backpressure: a push into a full FIFO is dropped and flags overrun.
module lc3_keyboard_fifo #(
    parameter int DEPTH  = 4,
    parameter int CHAR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    lc3_keyboard_fifo_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [CHAR_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic              ie;
    logic              ovr;

    logic empty;
    logic full;
    logic do_pop;
    logic do_push;
    logic ovr_set;
    logic unused_data;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = bus.RD_KBDR && !empty;
    // A pop in the same edge frees the slot the push lands in, so full+pop is not an overrun.
    assign do_push = bus.LD_char && (!full || do_pop);
    assign ovr_set = bus.LD_char && full && !do_pop;

    assign unused_data = ^{bus.DATA[15], bus.DATA[12:0]};

    // Entry contents survive reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= bus.I_char;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ie  <= 1'b0;
            ovr <= 1'b0;
        end else begin
            if (bus.LD_KBSR) begin
                ie <= bus.DATA[14];
            end
            // Setting overrun takes priority over a same-edge write-1-to-clear.
            if (ovr_set) begin
                ovr <= 1'b1;
            end else if (bus.LD_KBSR && bus.DATA[13]) begin
                ovr <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.KBDR = '0;
        if (!empty) begin
            bus.KBDR[CHAR_W-1:0] = mem[rd_ptr];
        end
    end

    always_comb begin
        bus.KBSR           = '0;
        bus.KBSR[CW-1:0]   = count;
        bus.KBSR[13]       = ovr;
        bus.KBSR[14]       = ie;
        bus.KBSR[15]       = !empty;
    end

    assign bus.KB_INT = !empty && ie;

endmodule

// File: doc/lc3_keyboard_fifo.md
LC3_KEYBOARD_FIFO -- requirements
Module: lc3_keyboard_fifo

Interface
REQ-001 The block SHALL have these parameters, one per line (name, default, meaning):
 - DEPTH, 4, number of character entries; power of two, 2..4096.
 - CHAR_W, 8, character width in bits; 1..16.
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
 - clk, input, 1, single system clock; all state changes on its rising edge.
 - reset, input, 1, asynchronous, active-high reset.
 - LD_KBSR, input, 1, CPU write strobe for the status register.
 - RD_KBDR, input, 1, CPU read strobe for the data register; pops one character.
 - DATA, input, 16, CPU write data for the status register.
 - I_char, input, CHAR_W, incoming character from the keyboard.
 - LD_char, input, 1, one-cycle strobe: I_char is valid.
 - KBDR, output, 16, head character, zero-extended.
 - KBSR, output, 16, status register.
 - KB_INT, output, 1, interrupt request, level.
REQ-003 The design SHALL have one clock domain, clk. Reset SHALL be asynchronous and active-high on port reset.

Function
REQ-004 Storage SHALL be a circular FIFO of DEPTH entries with read pointer, write pointer and occupancy count. The count SHALL be 0..DEPTH, (log2(DEPTH)+1) bits wide. Both pointers SHALL wrap modulo DEPTH.
REQ-005 Push: on a clock edge with LD_char=1 and the FIFO not full, I_char SHALL be written at the write pointer and the write pointer SHALL advance.
REQ-006 Pop: on a clock edge with RD_KBDR=1 and count>0, the read pointer SHALL advance. RD_KBDR with count=0 SHALL have no effect.
REQ-007 Simultaneous LD_char and RD_KBDR:
 - With count>0, both the push and the pop SHALL occur and the count SHALL stay the same. This includes count=DEPTH, with no overrun.
 - With count=0, only the push SHALL occur.
REQ-008 LD_char while full without an effective pop SHALL drop the character, leave the FIFO unchanged and set the overrun flag KBSR[13].
REQ-009 KBDR SHALL be combinational from storage: {(16-CHAR_W) zeros, entry[read pointer]} when count>0, and 16'h0000 when count=0. A character pushed at edge N SHALL appear on KBDR immediately after edge N when the FIFO was empty.
REQ-010 KBSR bits:
 - [15] ready = (count != 0), read-only.
 - [14] interrupt enable IE, read/write.
 - [13] overrun OVR, sticky, write-1-to-clear.
 - [12:0] count, zero-extended, read-only.
REQ-011 LD_KBSR=1 SHALL load IE from DATA[14]. It SHALL clear OVR when DATA[13]=1. It SHALL ignore all other DATA bits.
REQ-012 If OVR is being set (REQ-008) and cleared by LD_KBSR in the same edge, set SHALL win.
REQ-013 KB_INT SHALL equal KBSR[15] & KBSR[14], combinational, with no additional latency.
REQ-014 LD_KBSR, RD_KBDR and LD_char SHALL all be honoured in the same cycle, independently, as above.

Reset
REQ-015 Asserting reset SHALL immediately clear, without waiting for a clock edge: both pointers, count, IE and OVR. The outputs SHALL then be KBDR=16'h0000, KBSR=16'h0000 and KB_INT=0.
REQ-016 Reset asserted mid-operation SHALL discard all buffered characters. Stored entry contents need not be cleared.
REQ-017 After reset deassertion, the first clock edge SHALL process strobes normally.

Verification (DEPTH=4, CHAR_W=8)
REQ-018 The bench SHALL cover these directed scenarios:
 - Push 'A'(8'h41) with IE=0 -> next cycle KBDR=16'h0041, KBSR=16'h8001, KB_INT=0. Then pulse RD_KBDR -> KBSR=16'h0000, KBDR=16'h0000.
 - Write DATA=16'h4000, then push 8'h31, 8'h32, 8'h33 -> KBSR=16'hC003, KB_INT=1. Three pops -> KBDR shows 8'h31, 8'h32, 8'h33 in order; KB_INT falls after the third pop.
 - Push 5 characters into an empty FIFO (IE=0) -> KBSR=16'hA004, and the first 4 characters are retained. Write DATA=16'h2000 -> KBSR=16'h8004.
 - Full FIFO, LD_char and RD_KBDR together -> count stays 4, OVR stays 0, new character is at the tail.
 - Empty FIFO, LD_char and RD_KBDR together -> count=1, KBDR=new character.
 - Wrap-around over 10 push/pop pairs gives correct order. Then assert reset asynchronously between edges -> KBSR=16'h0000 and KB_INT=0 before the next clk edge.
